// File: rtl/risc_v_mike_instruction_memory_ld.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : risc_v_mike_instruction_memory_ld
// Purpose  : Loadable instruction RAM for the RISC-V Mike core. After reset
//            every word is overwritten with CLEAR_VALUE (one word per cycle),
//            then the memory serves fetches through a request/valid handshake
//            and accepts program words through a load port. Misaligned and
//            out-of-range fetches, and out-of-range loads, are flagged.
// Ports    : clk, rst (async, active-low)
//            fetch_req/fetch_addr  -> fetch_ready, fetch_valid, fetch_data,
//                                     fetch_err
//            load_en/load_addr/load_data -> load_ack, load_err
//            init_done : clear sequence finished
// Revision : 1.0 - initial release
// ============================================================================
module risc_v_mike_instruction_memory_ld #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 1024,
    parameter int                    ADDR_W      = 32,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = DATA_WIDTH'(32'h0000_0013),
    parameter int                    LD_AW       = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req,
    input  logic [ADDR_W-1:0]     fetch_addr,
    output logic                  fetch_ready,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_err,
    input  logic                  load_en,
    input  logic [LD_AW-1:0]      load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ack,
    output logic                  load_err,
    output logic                  init_done
);

    localparam int                c_BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam logic [LD_AW-1:0]  c_LAST_IDX   = LD_AW'(DEPTH - 1);
    localparam logic [LD_AW:0]    c_DEPTH_LD   = (LD_AW + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_DEPTH_FA   = ADDR_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LD_AW-1:0]      r_clr_cnt;
    logic [LD_AW-1:0]      w_clr_cnt_nxt;
    logic                  w_clr_we;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic [ADDR_W-1:0]     w_word_idx;
    logic [LD_AW-1:0]      w_rd_idx;
    logic                  w_misaligned;
    logic                  w_oor;
    logic                  w_fetch_acc;
    logic                  w_fetch_bad;
    logic                  w_ld_acc;
    logic                  w_ld_oor;
    logic                  w_ld_we;

    // First pipeline stage: request captured alongside the RAM read.
    logic                  r_fv;
    logic                  r_fe;
    logic                  r_la;
    logic                  r_le;

    // ------------------------------------------------------------------
    // Clear / run state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_clr_we      = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_we = 1'b1;
                if (r_clr_cnt == c_LAST_IDX) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + LD_AW'(1);
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
    end

    // Both flags come straight from the state register so reset clears them
    // without waiting for a clock edge.
    assign fetch_ready = (r_state == ST_RUN);
    assign init_done   = (r_state == ST_RUN);

    // ------------------------------------------------------------------
    // Fetch address decode (range check at full address width so high
    // address bits can never alias onto a valid word)
    // ------------------------------------------------------------------
    assign w_word_idx = fetch_addr >> c_BYTE_SHIFT;
    assign w_rd_idx   = w_word_idx[LD_AW-1:0];
    assign w_oor      = (w_word_idx >= c_DEPTH_FA);

    generate
        if (c_BYTE_SHIFT > 0) begin : g_align_chk
            assign w_misaligned = |fetch_addr[c_BYTE_SHIFT-1:0];
        end else begin : g_no_align_chk
            assign w_misaligned = 1'b0;
        end
    endgenerate

    assign w_fetch_acc = fetch_req & fetch_ready;
    assign w_fetch_bad = w_misaligned | w_oor;

    assign w_ld_acc = load_en & (r_state == ST_RUN);
    assign w_ld_oor = ({1'b0, load_addr} >= c_DEPTH_LD);
    assign w_ld_we  = w_ld_acc & ~w_ld_oor;

    // ------------------------------------------------------------------
    // Storage. The read sits in the same process as the write so a fetch
    // and a load to the same word on one edge sees the old contents.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_cnt] <= CLEAR_VALUE;
        end else if (w_ld_we) begin
            r_mem[load_addr] <= load_data;
        end
        if (w_fetch_acc && !w_fetch_bad) begin
            r_rd_data <= r_mem[w_rd_idx];
        end
    end

    // ------------------------------------------------------------------
    // Response pipeline: stage one tracks the accepted request, stage two
    // drives the registered outputs one edge later.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fv        <= 1'b0;
            r_fe        <= 1'b0;
            r_la        <= 1'b0;
            r_le        <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_err   <= 1'b0;
            fetch_data  <= '0;
            load_ack    <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            r_fv        <= w_fetch_acc;
            r_fe        <= w_fetch_acc & w_fetch_bad;
            r_la        <= w_ld_acc;
            r_le        <= w_ld_acc & w_ld_oor;
            fetch_valid <= r_fv;
            fetch_err   <= r_fe;
            load_ack    <= r_la;
            load_err    <= r_le;
            // Data only changes with a result; it holds between results.
            if (r_fv) begin
                fetch_data <= r_fe ? CLEAR_VALUE : r_rd_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/risc_v_mike_instruction_memory_ld.md
# risc_v_mike_instruction_memory_ld

Parametrised, loadable instruction memory for the RISC-V Mike core. It replaces the fixed, hard-wired program image with a RAM that is cleared to NOP after reset and then written through a program-load port. The fetch stage reads it through a request/valid handshake with 1-cycle registered latency. Misaligned and out-of-range fetch addresses are flagged rather than silently aliased.

## Interface
- DATA_WIDTH, 32: instruction word width in bits; multiple of 8.
- DEPTH, 1024: number of words; need not be a power of two.
- ADDR_W, 32: fetch byte-address width.
- CLEAR_VALUE, 32'h00000013: value written to every word after reset, and returned on a fetch error (addi x0,x0,0).
- LD_AW, $clog2(DEPTH): load word-index width (derived).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  byte address of the requested instruction.
- fetch_ready  out  1  fetch port can accept a request.
- fetch_valid  out  1  fetch_data/fetch_err valid; one-cycle pulse per accepted request.
- fetch_data  out  DATA_WIDTH  instruction word.
- fetch_err  out  1  accepted address was misaligned or out of range.
- load_en  in  1  program-load write strobe.
- load_addr  in  LD_AW  word index to write.
- load_data  in  DATA_WIDTH  word to write.
- load_ack  out  1  load accepted and written; one-cycle pulse.
- load_err  out  1  load_addr >= DEPTH; write discarded; pulses with load_ack.
- init_done  out  1  clear sequence complete.

## Operation
- States: CLEAR, RUN. Reset enters CLEAR with clear counter = 0.
- CLEAR:
  - Each cycle, write CLEAR_VALUE to word[counter] and increment the counter.
  - After word DEPTH-1 is written, go to RUN and set init_done = 1.
  - fetch_ready = 0. fetch_req and load_en are ignored; no ack and no valid are produced.
- RUN: fetch_ready = 1 permanently. init_done stays 1 until reset.
- Fetch is accepted when fetch_req && fetch_ready.
  - Word index = fetch_addr >> log2(DATA_WIDTH/8).
  - misaligned = |fetch_addr[log2(DATA_WIDTH/8)-1:0].
  - out_of_range = word index >= DEPTH. Compute at full ADDR_W width; no truncation.
  - On error: fetch_err = 1, fetch_data = CLEAR_VALUE, memory is not read.
- Load is accepted in RUN when load_en = 1.
  - load_addr < DEPTH: write the word, pulse load_ack next cycle, load_err = 0.
  - Otherwise: no write; load_ack = 1 and load_err = 1 next cycle.
- Simultaneous load and fetch to the same word: the fetch returns the old contents (read-before-write). The new value is visible to the next fetch.
- Mid-operation reset (any state): memory contents are undefined except that CLEAR rewrites all of them. In-flight fetch_valid and load_ack are dropped.

## Timing
- Reset values: fetch_ready 0, fetch_valid 0, fetch_data 0, fetch_err 0, load_ack 0, load_err 0, init_done 0.
- Clear duration: exactly DEPTH cycles after reset deassertion. init_done and fetch_ready rise on the edge that completes the write to word DEPTH-1.
- Fetch latency: request accepted at edge N; fetch_valid, fetch_data and fetch_err are registered and valid after edge N+1 for exactly one cycle.
  - Back-to-back requests give one result every cycle; no bubbles.
  - fetch_data holds its last value when fetch_valid = 0.
- Load latency: strobe sampled at edge N; memory is updated at edge N; load_ack/load_err are high after edge N+1 for one cycle.
  - A fetch of that word accepted at edge N+1 or later returns the new data.
- Reset assertion forces all outputs to their reset values immediately, without waiting for a clock edge.

## Test plan
- DEPTH=16: release reset → init_done/fetch_ready stay 0 for 16 cycles, then rise. Then fetch 0x0, 0x4 … 0x3C back-to-back → 16 consecutive valids, each with data 0x00000013 and err 0.
- load_en at idx 3 with 0x002081b3 → load_ack one cycle later, load_err 0. Then fetch 0xC → valid one cycle after accept, data 0x002081b3.
- Fetch 0x6 → fetch_err 1, data 0x00000013. With DEPTH=16, fetch 0x40 → fetch_err 1. Fetch 0x3C → err 0.
- DEPTH=12: load idx 13 → load_ack 1 and load_err 1. A following fetch of 0x34 returns err 1; no memory word is changed.
- Same cycle: load idx 5 = 0xDEADBEEF and fetch 0x14 → returns the prior value. Next fetch of 0x14 → 0xDEADBEEF.
- Assert rst mid-CLEAR (counter = 7) and mid-fetch → outputs go to reset values immediately. After release, the clear takes a full DEPTH cycles again and all words read 0x00000013.
